// File: rtl/mem_stage_lsu.sv
// MIPS memory stage: load/store unit on a request/grant/response bus, with lane decode,
// load extension, alignment and timeout exceptions, and the M->W pipeline register.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  M_valid,
  input  logic [31:0]           M_PC,
  input  logic [31:0]           M_Ins,
  input  logic [3:0]            M_memop,
  input  logic [DATA_W-1:0]     M_ALU_Y,
  input  logic [DATA_W-1:0]     M_rt_fw,
  input  logic [4:0]            M_GRF_WA,
  output logic [DATA_W-1:0]     M_GRF_WD,
  output logic                  M_fwd_valid,
  output logic                  M_stall,
  output logic                  dm_req,
  output logic                  dm_we,
  output logic [ADDR_W-1:0]     dm_addr,
  output logic [DATA_W/8-1:0]   dm_be,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic                  dm_gnt,
  input  logic                  dm_rvalid,
  input  logic [DATA_W-1:0]     dm_rdata,
  output logic                  W_valid,
  output logic [31:0]           W_PC,
  output logic [31:0]           W_Ins,
  output logic [4:0]            W_GRF_WA,
  output logic [DATA_W-1:0]     W_ALU_Y,
  output logic [DATA_W-1:0]     W_DM_RD,
  output logic                  W_exc,
  output logic [4:0]            W_excode
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       ins;
    logic [4:0]        wa;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] dm_rd;
    logic              exc;
    logic [4:0]        excode;
  } w_reg_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  w_reg_t           w_q, w_d;

  logic              is_load, is_store, is_signed;
  logic [1:0]        sz;
  logic              access, misaligned, aligned_access;
  logic [ADDR_W-1:0] addr;
  logic [OFF_W-1:0]  offset, size_mask;
  logic [7:0]        be_base;
  logic [DATA_W-1:0] shifted, keep_mask, load_data;
  logic              sign_bit;
  logic              done_ok, timeout, complete;

  // Opcode decode; 64-bit-only ops fall back to "no memory op" on a 32-bit datapath.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    sz        = 2'd0;
    case (M_memop)
      4'd1:  begin is_load = 1'b1; is_signed = 1'b1; sz = 2'd0; end
      4'd2:  begin is_load = 1'b1; sz = 2'd0; end
      4'd3:  begin is_load = 1'b1; is_signed = 1'b1; sz = 2'd1; end
      4'd4:  begin is_load = 1'b1; sz = 2'd1; end
      4'd5:  begin is_load = 1'b1; is_signed = 1'b1; sz = 2'd2; end
      4'd6:  if (DATA_W == 64) begin is_load = 1'b1; sz = 2'd2; end
      4'd7:  if (DATA_W == 64) begin is_load = 1'b1; sz = 2'd3; end
      4'd9:  begin is_store = 1'b1; sz = 2'd0; end
      4'd10: begin is_store = 1'b1; sz = 2'd1; end
      4'd11: begin is_store = 1'b1; sz = 2'd2; end
      4'd12: if (DATA_W == 64) begin is_store = 1'b1; sz = 2'd3; end
      default: ;
    endcase
  end

  assign addr           = M_ALU_Y[ADDR_W-1:0];
  assign offset         = addr[OFF_W-1:0];
  assign size_mask      = OFF_W'((4'd1 << sz) - 4'd1);
  assign access         = M_valid & (is_load | is_store);
  assign misaligned     = access & (|(offset & size_mask));
  assign aligned_access = access & ~misaligned;

  assign M_GRF_WD    = M_ALU_Y;
  assign M_fwd_valid = M_valid & (|M_GRF_WA) & ~is_load;

  // Loads fetch the whole lane group; stores enable only the addressed bytes.
  always_comb begin
    case (sz)
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    case (sz)
      2'd0:    dm_wdata = {LANES{M_rt_fw[7:0]}};
      2'd1:    dm_wdata = {(LANES/2){M_rt_fw[15:0]}};
      2'd2:    dm_wdata = {(LANES/4){M_rt_fw[31:0]}};
      default: dm_wdata = M_rt_fw;
    endcase
  end

  assign dm_we   = is_store;
  assign dm_be   = is_store ? (LANES'(be_base) << offset) : '1;
  assign dm_addr = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Load alignment: shift the addressed lane down, keep `size` bytes, then extend.
  always_comb begin
    shifted = dm_rdata >> {offset, 3'b000};
    case (sz)
      2'd0:    begin keep_mask = DATA_W'(8'hFF);        sign_bit = shifted[7];  end
      2'd1:    begin keep_mask = DATA_W'(16'hFFFF);     sign_bit = shifted[15]; end
      2'd2:    begin keep_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin keep_mask = '1;                     sign_bit = shifted[DATA_W-1]; end
    endcase
    load_data = shifted & keep_mask;
    if (is_signed && sign_bit) begin
      load_data = load_data | ~keep_mask;
    end
  end

  // Bus handshake FSM; timeout overrides everything except a genuine completion.
  always_comb begin
    state_d = state_q;
    dm_req  = 1'b0;
    done_ok = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aligned_access) begin
          dm_req = 1'b1;
          if (!dm_gnt)       state_d = S_REQ;
          else if (is_store) done_ok = 1'b1;
          else               state_d = S_RESP;
        end
      end
      S_REQ: begin
        dm_req = 1'b1;
        if (dm_gnt) begin
          if (is_store) begin
            done_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (dm_rvalid) begin
          done_ok = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !done_ok && cnt_q == CNT_W'(TIMEOUT - 1)) begin
      timeout = 1'b1;
      state_d = S_IDLE;
    end
    cnt_d = (state_d == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
  end

  assign complete = done_ok | timeout;
  assign M_stall  = aligned_access & ~complete;

  // A stalled cycle hands W a bubble; otherwise W takes M plus any exception.
  always_comb begin
    w_d = '0;
    if (!M_stall) begin
      w_d.valid = M_valid;
      w_d.pc    = M_PC;
      w_d.ins   = M_Ins;
      w_d.alu_y = M_ALU_Y;
      if (misaligned) begin
        w_d.exc    = 1'b1;
        w_d.excode = is_load ? EXC_ADEL : EXC_ADES;
      end else if (timeout) begin
        w_d.exc    = 1'b1;
        w_d.excode = EXC_DBE;
      end
      w_d.wa = w_d.exc ? 5'd0 : M_GRF_WA;
      if (done_ok && is_load) begin
        w_d.dm_rd = load_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  assign W_valid  = w_q.valid;
  assign W_PC     = w_q.pc;
  assign W_Ins    = w_q.ins;
  assign W_GRF_WA = w_q.wa;
  assign W_ALU_Y  = w_q.alu_y;
  assign W_DM_RD  = w_q.dm_rd;
  assign W_exc    = w_q.exc;
  assign W_excode = w_q.excode;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a 32-bit and a 64-bit instance share one stimulus
// stream; expected values come from an arithmetic model of the memory-op rules.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        M_valid;
  logic [31:0] M_PC, M_Ins;
  logic [3:0]  M_memop;
  logic [63:0] M_ALU_Y, M_rt_fw;
  logic [4:0]  M_GRF_WA;
  logic        dm_gnt, dm_rvalid;
  logic [63:0] dm_rdata;

  logic [31:0] a_gwd, a_addr, a_wdata, a_W_PC, a_W_Ins, a_W_ALU_Y, a_W_DM_RD;
  logic        a_fwd, a_stall, a_req, a_we, a_W_valid, a_W_exc;
  logic [3:0]  a_be;
  logic [4:0]  a_W_WA, a_W_excode;

  logic [63:0] b_gwd, b_wdata, b_W_ALU_Y, b_W_DM_RD;
  logic [31:0] b_addr, b_W_PC, b_W_Ins;
  logic        b_fwd, b_stall, b_req, b_we, b_W_valid, b_W_exc;
  logic [7:0]  b_be;
  logic [4:0]  b_W_WA, b_W_excode;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc, exp_ins;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(16)) dut32 (
    .clk(clk), .reset(reset), .M_valid(M_valid), .M_PC(M_PC), .M_Ins(M_Ins),
    .M_memop(M_memop), .M_ALU_Y(M_ALU_Y[31:0]), .M_rt_fw(M_rt_fw[31:0]), .M_GRF_WA(M_GRF_WA),
    .M_GRF_WD(a_gwd), .M_fwd_valid(a_fwd), .M_stall(a_stall),
    .dm_req(a_req), .dm_we(a_we), .dm_addr(a_addr), .dm_be(a_be), .dm_wdata(a_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata[31:0]),
    .W_valid(a_W_valid), .W_PC(a_W_PC), .W_Ins(a_W_Ins), .W_GRF_WA(a_W_WA),
    .W_ALU_Y(a_W_ALU_Y), .W_DM_RD(a_W_DM_RD), .W_exc(a_W_exc), .W_excode(a_W_excode)
  );

  mem_stage_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) dut64 (
    .clk(clk), .reset(reset), .M_valid(M_valid), .M_PC(M_PC), .M_Ins(M_Ins),
    .M_memop(M_memop), .M_ALU_Y(M_ALU_Y), .M_rt_fw(M_rt_fw), .M_GRF_WA(M_GRF_WA),
    .M_GRF_WD(b_gwd), .M_fwd_valid(b_fwd), .M_stall(b_stall),
    .dm_req(b_req), .dm_we(b_we), .dm_addr(b_addr), .dm_be(b_be), .dm_wdata(b_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .W_valid(b_W_valid), .W_PC(b_W_PC), .W_Ins(b_W_Ins), .W_GRF_WA(b_W_WA),
    .W_ALU_Y(b_W_ALU_Y), .W_DM_RD(b_W_DM_RD), .W_exc(b_W_exc), .W_excode(b_W_excode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd9:  return 1;
      4'd3, 4'd4, 4'd10: return 2;
      4'd5, 4'd6, 4'd11: return 4;
      4'd7, 4'd12:       return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [63:0] rd, input bit w64);
    int lanes, sz, off;
    logic [63:0] v, m;
    lanes = w64 ? 8 : 4;
    sz    = op_size(op);
    off   = int'(addr % lanes);
    m     = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
    v     = (rd >> (8 * off)) & m;
    if ((op == 4'd1 || op == 4'd3 || op == 4'd5) && v[8 * sz - 1]) v = v | ~m;
    if (!w64) v = {32'h0, v[31:0]};
    return v;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_m(input logic v, input logic [3:0] op, input logic [63:0] y,
                       input logic [63:0] rt, input logic [4:0] wa);
    exp_pc   = $urandom;
    exp_ins  = $urandom;
    M_valid  = v;
    M_PC     = exp_pc;
    M_Ins    = exp_ins;
    M_memop  = op;
    M_ALU_Y  = y;
    M_rt_fw  = rt;
    M_GRF_WA = wa;
  endtask

  task automatic set_bus(input logic g, input logic rv, input logic [63:0] rd);
    dm_gnt    = g;
    dm_rvalid = rv;
    dm_rdata  = rd;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++; if ({a_W_valid, a_W_PC, a_W_Ins, a_W_WA, a_W_ALU_Y, a_W_DM_RD, a_W_exc, a_W_excode} !== '0) begin
      errors++; $display("FAIL reset_w32 got valid=%b pc=%h alu=%h", a_W_valid, a_W_PC, a_W_ALU_Y); end
    checks++; if ({b_W_valid, b_W_DM_RD, b_W_exc} !== '0) begin
      errors++; $display("FAIL reset_w64 got valid=%b rd=%h exc=%b", b_W_valid, b_W_DM_RD, b_W_exc); end
    checks++; if (a_req !== 1'b0 || a_stall !== 1'b0) begin
      errors++; $display("FAIL reset_bus got req=%b stall=%b want 0 0", a_req, a_stall); end
    @(negedge clk); reset = 1'b0;
    set_m(1'b1, 4'd0, 64'h1234_5678, 64'h0, 5'd7);
    @(posedge clk); #1;
    checks++; if (a_W_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre got W_valid=%b want 1", a_W_valid); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({a_W_valid, a_W_PC, a_W_WA, a_W_ALU_Y} !== '0) begin
      errors++; $display("FAIL reset_async got valid=%b wa=%0d alu=%h want all 0", a_W_valid, a_W_WA, a_W_ALU_Y); end
    @(negedge clk); reset = 1'b0; set_m(1'b0, 4'd0, 64'h0, 64'h0, 5'd0);
  endtask

  task automatic test_nonmem();
    for (int i = 0; i < 6; i++) begin
      logic [63:0] y;
      logic [4:0]  wa;
      y  = {$urandom, $urandom};
      wa = 5'($urandom);
      @(negedge clk); set_m(1'b1, 4'd0, y, {$urandom, $urandom}, wa); set_bus(1'b0, 1'b0, 64'h0); #1;
      checks++; if (a_stall !== 1'b0 || a_req !== 1'b0) begin
        errors++; $display("FAIL nonmem_stall got stall=%b req=%b want 0 0", a_stall, a_req); end
      checks++; if (a_fwd !== (wa != 5'd0) || a_gwd !== y[31:0]) begin
        errors++; $display("FAIL nonmem_fwd got fwd=%b wd=%h want %b %h", a_fwd, a_gwd, wa != 5'd0, y[31:0]); end
      @(posedge clk); #1;
      checks++; if (a_W_valid !== 1'b1 || a_W_ALU_Y !== y[31:0] || a_W_WA !== wa || a_W_PC !== exp_pc
                    || a_W_DM_RD !== 32'h0 || a_W_exc !== 1'b0) begin
        errors++; $display("FAIL nonmem_w got valid=%b alu=%h wa=%0d rd=%h exc=%b want 1 %h %0d 0 0",
                           a_W_valid, a_W_ALU_Y, a_W_WA, a_W_DM_RD, a_W_exc, y[31:0], wa); end
    end
  endtask

  task automatic test_lw_latency();
    @(negedge clk); set_m(1'b1, 4'd5, 64'h100, 64'h0, 5'd8); set_bus(1'b1, 1'b0, 64'h0); #1;
    checks++; if (a_stall !== 1'b1 || a_req !== 1'b1) begin
      errors++; $display("FAIL lw_c0 got stall=%b req=%b want 1 1", a_stall, a_req); end
    @(posedge clk); #1;
    checks++; if (a_W_valid !== 1'b0) begin errors++; $display("FAIL lw_bubble0 got W_valid=%b want 0", a_W_valid); end
    @(negedge clk); set_bus(1'b0, 1'b0, 64'h0); #1;
    checks++; if (a_stall !== 1'b1 || a_req !== 1'b0) begin
      errors++; $display("FAIL lw_c1 got stall=%b req=%b want 1 0", a_stall, a_req); end
    @(negedge clk); set_bus(1'b0, 1'b1, 64'h8000_00F0); #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lw_c2 got stall=%b want 0", a_stall); end
    @(posedge clk); #1;
    checks++; if (a_W_DM_RD !== 32'h8000_00F0 || a_W_valid !== 1'b1 || a_W_WA !== 5'd8) begin
      errors++; $display("FAIL lw_data got rd=%h valid=%b wa=%0d want 800000f0 1 8", a_W_DM_RD, a_W_valid, a_W_WA); end
  endtask

  task automatic test_byte_ext();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] want;
      want = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      @(negedge clk); set_m(1'b1, (k == 0) ? 4'd1 : 4'd2, 64'h103, 64'h0, 5'd3); set_bus(1'b1, 1'b0, 64'h0); #1;
      checks++; if (a_be !== 4'hF || a_addr !== 32'h100 || a_we !== 1'b0) begin
        errors++; $display("FAIL lb_bus%0d got be=%h addr=%h we=%b want f 100 0", k, a_be, a_addr, a_we); end
      @(negedge clk); set_bus(1'b0, 1'b1, {$urandom, 32'h80AA_BBCC}); #1;
      @(posedge clk); #1;
      checks++; if (a_W_DM_RD !== want) begin
        errors++; $display("FAIL lb_ext%0d got %h want %h", k, a_W_DM_RD, want); end
    end
  endtask

  task automatic test_store_stall();
    @(negedge clk); set_m(1'b1, 4'd10, 64'h102, 64'h1234_ABCD, 5'd0);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      set_bus(c == 3, 1'b0, 64'h0); #1;
      checks++; if (a_req !== 1'b1 || a_stall !== (c != 3)) begin
        errors++; $display("FAIL sh_c%0d got req=%b stall=%b want 1 %b", c, a_req, a_stall, c != 3); end
      checks++; if (a_be !== 4'b1100 || a_wdata !== 32'hABCD_ABCD || a_we !== 1'b1) begin
        errors++; $display("FAIL sh_lanes got be=%b wdata=%h we=%b", a_be, a_wdata, a_we); end
      @(posedge clk); #1;
      checks++; if (a_W_valid !== (c == 3) || a_W_exc !== 1'b0) begin
        errors++; $display("FAIL sh_w%0d got W_valid=%b exc=%b want %b 0", c, a_W_valid, a_W_exc, c == 3); end
    end
  endtask

  task automatic test_misaligned();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] code;
      code = (k == 0) ? 5'd4 : 5'd5;
      @(negedge clk); set_m(1'b1, (k == 0) ? 4'd5 : 4'd11, (k == 0) ? 64'h102 : 64'h101, 64'h0, 5'd12);
      set_bus(1'b1, 1'b0, 64'h0); #1;
      checks++; if (a_req !== 1'b0 || a_stall !== 1'b0) begin
        errors++; $display("FAIL mis_bus%0d got req=%b stall=%b want 0 0", k, a_req, a_stall); end
      @(posedge clk); #1;
      checks++; if (a_W_exc !== 1'b1 || a_W_excode !== code || a_W_WA !== 5'd0 || a_W_valid !== 1'b1) begin
        errors++; $display("FAIL mis_exc%0d got exc=%b code=%0d wa=%0d want 1 %0d 0", k, a_W_exc, a_W_excode, a_W_WA, code); end
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); set_m(1'b1, 4'd5, 64'h200, 64'h0, 5'd6); set_bus(1'b1, 1'b0, 64'h0);
    for (int c = 0; c < 16; c++) begin
      if (c != 0) begin @(negedge clk); set_bus(1'b0, 1'b0, 64'h0); end
      #1;
      checks++; if (a_stall !== (c != 15)) begin
        errors++; $display("FAIL to_stall c%0d got %b want %b", c, a_stall, c != 15); end
      @(posedge clk); #1;
      if (c != 15) begin
        checks++; if (a_W_valid !== 1'b0) begin errors++; $display("FAIL to_bubble c%0d got W_valid=%b want 0", c, a_W_valid); end
      end
    end
    checks++; if (a_W_exc !== 1'b1 || a_W_excode !== 5'd7 || a_W_WA !== 5'd0 || a_W_DM_RD !== 32'h0) begin
      errors++; $display("FAIL to_dbe got exc=%b code=%0d wa=%0d rd=%h want 1 7 0 0", a_W_exc, a_W_excode, a_W_WA, a_W_DM_RD); end
    @(negedge clk); set_m(1'b0, 4'd0, 64'h0, 64'h0, 5'd0);
    @(negedge clk); set_m(1'b1, 4'd5, 64'h300, 64'h0, 5'd4); set_bus(1'b0, 1'b1, 64'h1111_2222); #1;
    checks++; if (a_stall !== 1'b1 || a_req !== 1'b1) begin
      errors++; $display("FAIL to_late_rvalid got stall=%b req=%b want 1 1", a_stall, a_req); end
    @(negedge clk); set_bus(1'b1, 1'b0, 64'h0);
    @(negedge clk); set_bus(1'b0, 1'b1, 64'h0000_0055); #1;
    @(posedge clk); #1;
    checks++; if (a_W_DM_RD !== 32'h55 || a_W_exc !== 1'b0) begin
      errors++; $display("FAIL to_recover got rd=%h exc=%b want 55 0", a_W_DM_RD, a_W_exc); end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk); set_m(1'b1, 4'd5, 64'h240, 64'h0, 5'd9); set_bus(1'b1, 1'b0, 64'h0);
    @(negedge clk); set_bus(1'b0, 1'b0, 64'h0); #1;
    checks++; if (a_req !== 1'b0 || a_stall !== 1'b1) begin
      errors++; $display("FAIL rr_resp got req=%b stall=%b want 0 1", a_req, a_stall); end
    #2 reset = 1'b1; #1;
    checks++; if (a_req !== 1'b1 || {a_W_valid, a_W_PC, a_W_DM_RD, a_W_exc} !== '0) begin
      errors++; $display("FAIL rr_abort got req=%b W_valid=%b rd=%h want 1 0 0", a_req, a_W_valid, a_W_DM_RD); end
    @(negedge clk); reset = 1'b0; set_m(1'b0, 4'd0, 64'h0, 64'h0, 5'd0); set_bus(1'b0, 1'b1, 64'hDEAD); #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rr_idle got stall=%b want 0", a_stall); end
    @(negedge clk); set_m(1'b1, 4'd5, 64'h240, 64'h0, 5'd9); set_bus(1'b0, 1'b1, 64'hBEEF); #1;
    checks++; if (a_stall !== 1'b1 || a_req !== 1'b1) begin
      errors++; $display("FAIL rr_ignore got stall=%b req=%b want 1 1", a_stall, a_req); end
    @(negedge clk); set_bus(1'b1, 1'b0, 64'h0);
    @(negedge clk); set_bus(1'b0, 1'b1, 64'h0000_00A5);
    @(posedge clk); #1;
    checks++; if (a_W_DM_RD !== 32'hA5 || a_W_WA !== 5'd9) begin
      errors++; $display("FAIL rr_after got rd=%h wa=%0d want a5 9", a_W_DM_RD, a_W_WA); end
  endtask

  task automatic test_dword();
    logic [63:0] d;
    d = 64'hF0E1_D2C3_B4A5_9687;
    @(negedge clk); set_m(1'b1, 4'd7, 64'h8, 64'h0, 5'd2); set_bus(1'b1, 1'b0, 64'h0); #1;
    checks++; if (b_be !== 8'hFF || b_addr !== 32'h8 || b_req !== 1'b1 || b_stall !== 1'b1) begin
      errors++; $display("FAIL ld_bus got be=%h addr=%h req=%b stall=%b", b_be, b_addr, b_req, b_stall); end
    @(negedge clk); set_bus(1'b0, 1'b1, d); #1;
    @(posedge clk); #1;
    checks++; if (b_W_DM_RD !== d || b_W_valid !== 1'b1) begin
      errors++; $display("FAIL ld_data got %h want %h", b_W_DM_RD, d); end
    @(negedge clk); set_m(1'b1, 4'd7, 64'hC, 64'h0, 5'd2); set_bus(1'b0, 1'b0, 64'h0); #1;
    checks++; if (b_req !== 1'b0 || b_stall !== 1'b0) begin
      errors++; $display("FAIL ld_mis_bus got req=%b stall=%b want 0 0", b_req, b_stall); end
    @(posedge clk); #1;
    checks++; if (b_W_exc !== 1'b1 || b_W_excode !== 5'd4 || b_W_WA !== 5'd0) begin
      errors++; $display("FAIL ld_adel got exc=%b code=%0d wa=%0d want 1 4 0", b_W_exc, b_W_excode, b_W_WA); end
  endtask

  task automatic test_random(input bit w64, input int n);
    for (int t = 0; t < n; t++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic [63:0] y, rt, rd, m, exp_wd, exp_rd, exp_alu;
      logic [7:0]  exp_be;
      logic [4:0]  wa, exp_code;
      int lanes, sz, gd, rdl, ncomp;
      bit ld, st, acc, mis;
      op = 4'($urandom_range(0, 12));
      if (op == 4'd8 || (!w64 && (op == 4'd6 || op == 4'd7 || op == 4'd12))) op = 4'd0;
      lanes = w64 ? 8 : 4;
      sz    = op_size(op);
      ld    = (op >= 4'd1 && op <= 4'd7);
      st    = (op >= 4'd9);
      acc   = ld || st;
      addr  = $urandom;
      if (acc && $urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'(sz - 1);
      mis   = acc && (addr % sz != 0);
      gd    = $urandom_range(0, 3);
      rdl   = $urandom_range(1, 3);
      ncomp = (!acc || mis) ? 0 : (st ? gd : gd + rdl);
      wa    = 5'($urandom);
      rt    = {$urandom, $urandom};
      rd    = {$urandom, $urandom};
      y     = {$urandom, addr};
      exp_alu = w64 ? y : {32'h0, y[31:0]};
      m       = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
      exp_wd  = '0;
      if (st) for (int i = 0; i < lanes / sz; i++) exp_wd = exp_wd | ((rt & m) << (8 * sz * i));
      if (!w64) exp_wd = {32'h0, exp_wd[31:0]};
      exp_be   = st ? 8'(((1 << sz) - 1) << (addr % lanes)) : (w64 ? 8'hFF : 8'h0F);
      exp_rd   = (ld && !mis) ? ref_load(op, addr, rd, w64) : 64'h0;
      exp_code = mis ? (ld ? 5'd4 : 5'd5) : 5'd0;
      for (int c = 0; c <= ncomp; c++) begin
        logic        o_stall, o_req, o_we, o_fwd, o_valid, o_exc;
        logic [7:0]  o_be;
        logic [31:0] o_addr, o_pc;
        logic [63:0] o_wd, o_gwd, o_rd, o_alu;
        logic [4:0]  o_wa, o_code;
        @(negedge clk);
        if (c == 0) set_m(1'b1, op, y, rt, wa);
        set_bus(acc && !mis && (c == gd || (c > gd && $urandom_range(0, 1) == 1)),
                (c <= gd) ? 1'($urandom_range(0, 1)) : (ld && c == ncomp),
                (c == ncomp) ? rd : {$urandom, $urandom});
        #1;
        o_stall = w64 ? b_stall : a_stall;
        o_req   = w64 ? b_req : a_req;
        o_we    = w64 ? b_we : a_we;
        o_fwd   = w64 ? b_fwd : a_fwd;
        o_be    = w64 ? b_be : {4'h0, a_be};
        o_addr  = w64 ? b_addr : a_addr;
        o_wd    = w64 ? b_wdata : {32'h0, a_wdata};
        o_gwd   = w64 ? b_gwd : {32'h0, a_gwd};
        checks++; if (o_stall !== (acc && !mis && c != ncomp) || o_req !== (acc && !mis && c <= gd)) begin
          errors++; $display("FAIL rnd%0d_%0d op%0d c%0d got stall=%b req=%b want %b %b", w64, t, op, c,
                             o_stall, o_req, acc && !mis && c != ncomp, acc && !mis && c <= gd); end
        if (c == 0) begin
          checks++; if (o_fwd !== (wa != 5'd0 && !ld) || o_gwd !== exp_alu) begin
            errors++; $display("FAIL rnd%0d_%0d fwd got %b %h want %b %h", w64, t, o_fwd, o_gwd, wa != 5'd0 && !ld, exp_alu); end
          if (acc && !mis) begin
            checks++; if (o_be !== exp_be || o_addr !== (addr & ~32'(lanes - 1)) || o_we !== st
                          || (st && o_wd !== exp_wd)) begin
              errors++; $display("FAIL rnd%0d_%0d op%0d bus got be=%h addr=%h we=%b wd=%h want %h %h %b %h", w64, t, op,
                                 o_be, o_addr, o_we, o_wd, exp_be, addr & ~32'(lanes - 1), st, exp_wd); end
          end
        end
        @(posedge clk); #1;
        o_valid = w64 ? b_W_valid : a_W_valid;
        o_exc   = w64 ? b_W_exc : a_W_exc;
        o_code  = w64 ? b_W_excode : a_W_excode;
        o_wa    = w64 ? b_W_WA : a_W_WA;
        o_rd    = w64 ? b_W_DM_RD : {32'h0, a_W_DM_RD};
        o_alu   = w64 ? b_W_ALU_Y : {32'h0, a_W_ALU_Y};
        o_pc    = w64 ? b_W_PC : a_W_PC;
        if (c != ncomp) begin
          checks++; if (o_valid !== 1'b0 || o_exc !== 1'b0) begin
            errors++; $display("FAIL rnd%0d_%0d bubble c%0d got valid=%b exc=%b want 0 0", w64, t, c, o_valid, o_exc); end
        end else begin
          checks++; if (o_valid !== 1'b1 || o_exc !== mis || o_code !== exp_code || o_wa !== (mis ? 5'd0 : wa)
                        || o_rd !== exp_rd || o_alu !== exp_alu || o_pc !== exp_pc) begin
            errors++; $display("FAIL rnd%0d_%0d op%0d addr=%h W got v=%b exc=%b code=%0d wa=%0d rd=%h alu=%h want 1 %b %0d %0d %h %h",
                               w64, t, op, addr, o_valid, o_exc, o_code, o_wa, o_rd, o_alu,
                               mis, exp_code, mis ? 5'd0 : wa, exp_rd, exp_alu); end
        end
      end
    end
    @(negedge clk); set_m(1'b0, 4'd0, 64'h0, 64'h0, 5'd0); set_bus(1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    set_m(1'b0, 4'd0, 64'h0, 64'h0, 5'd0);
    set_bus(1'b0, 1'b0, 64'h0);
    #3;
    test_reset();
    test_nonmem();
    test_lw_latency();
    test_byte_ext();
    test_store_stall();
    test_misaligned();
    test_timeout();
    test_reset_in_resp();
    test_dword();
    test_random(1'b0, 60);
    test_random(1'b1, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the scenario list completed");
    $fatal(1);
  end

endmodule
